// File: rtl/riscv_rf_pkg.sv
// Shared constants, address type and sizing helper for the register file slice.
package riscv_rf_pkg;

  localparam int unsigned NUM_INT_REGS = 32;
  localparam int unsigned NUM_FP_REGS  = 32;
  localparam int unsigned FP_BASE      = 32;

  // Widest address in use: 32 integer plus 32 FP registers.
  typedef logic [5:0] rf_addr_t;

  function automatic int unsigned rf_words(input bit fpu);
    return fpu ? (NUM_INT_REGS + NUM_FP_REGS) : NUM_INT_REGS;
  endfunction

endpackage

// File: rtl/riscv_register_file_sb_if.sv
// Read, write and reservation bundle between the ID stage (master) and the register file (slave).
interface riscv_register_file_sb_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RPORTS = 3,
  parameter int unsigned NUM_WPORTS = 2
);

  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_o;
  logic [NUM_RPORTS-1:0]                 rbusy_o;

  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WPORTS-1:0]                 we_i;
  logic [NUM_WPORTS-1:0]                 wrel_i;

  logic                                  rsv_valid_i;
  logic [ADDR_WIDTH-1:0]                 rsv_addr_i;
  logic                                  rsv_ready_o;
  logic                                  flush_i;
  logic [(2**ADDR_WIDTH)-1:0]            busy_vec_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, wrel_i, rsv_valid_i, rsv_addr_i, flush_i,
    input  rdata_o, rbusy_o, rsv_ready_o, busy_vec_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, wrel_i, rsv_valid_i, rsv_addr_i, flush_i,
    output rdata_o, rbusy_o, rsv_ready_o, busy_vec_o
  );

endinterface

// File: rtl/riscv_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by accepted reservations, cleared by
// releasing writes or a flush.
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NUM_WPORTS  = 2,
  parameter int unsigned NUM_ENTRIES = 2**ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]                 rsv_addr_i,
  input  logic                                  flush_i,
  input  logic [NUM_WPORTS-1:0]                 we_i,
  input  logic [NUM_WPORTS-1:0]                 wrel_i,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  output logic                                  rsv_ready_o,
  output logic [NUM_ENTRIES-1:0]                busy_vec_o
);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic                   rsv_ready;

  // Reservations to x0 are always accepted but never mark anything busy.
  assign rsv_ready = rsv_valid_i & ~flush_i &
                     ((rsv_addr_i == '0) | ~busy_q[rsv_addr_i]);

  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NUM_WPORTS; k++) begin
      if (we_i[k] && wrel_i[k]) begin
        busy_d[waddr_i[k]] = 1'b0;
      end
    end
    // Applied after releases so a back-to-back producer keeps the bit set.
    if (rsv_ready && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rsv_ready_o = rsv_ready;
  assign busy_vec_o  = busy_q;

endmodule

// File: rtl/riscv_register_file_sb.sv
// Integer/FP register file with N read / M write ports, optional write-to-read bypass and
// an attached hazard scoreboard.
module riscv_register_file_sb
  import riscv_rf_pkg::*;
#(
  parameter int unsigned FPU        = 0,
  parameter int unsigned ADDR_WIDTH = 5 + FPU,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RPORTS = 3,
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned BYPASS     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     test_en_i,
  riscv_register_file_sb_if.slave  bus
);

  localparam int unsigned NUM_WORDS   = rf_words(FPU != 0);
  localparam int unsigned NUM_ENTRIES = 2**ADDR_WIDTH;

  if (ADDR_WIDTH != 5 + FPU) begin : g_bad_addr_width
    $error("riscv_register_file_sb: ADDR_WIDTH must equal 5+FPU");
  end
  if ((FPU != 0) && (NUM_WORDS != FP_BASE + NUM_FP_REGS)) begin : g_bad_fp_map
    $error("riscv_register_file_sb: FP registers must sit directly above the integer file");
  end
  if ((NUM_RPORTS < 1) || (NUM_RPORTS > 4)) begin : g_bad_rports
    $error("riscv_register_file_sb: NUM_RPORTS must be 1..4");
  end
  if ((NUM_WPORTS < 1) || (NUM_WPORTS > 3)) begin : g_bad_wports
    $error("riscv_register_file_sb: NUM_WPORTS must be 1..3");
  end

  // DFT hook only; it has no functional effect.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];

  // Ascending port order lets the highest-indexed writer win on a collision.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned k = 0; k < NUM_WPORTS; k++) begin
      if (bus.we_i[k] && (bus.waddr_i[k] != '0)) begin
        mem_d[bus.waddr_i[k]] = bus.wdata_i[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [NUM_ENTRIES-1:0] busy_vec;

  riscv_rf_scoreboard #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_WPORTS  (NUM_WPORTS),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsv_valid_i (bus.rsv_valid_i),
    .rsv_addr_i  (bus.rsv_addr_i),
    .flush_i     (bus.flush_i),
    .we_i        (bus.we_i),
    .wrel_i      (bus.wrel_i),
    .waddr_i     (bus.waddr_i),
    .rsv_ready_o (bus.rsv_ready_o),
    .busy_vec_o  (busy_vec)
  );

  logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata;
  logic [NUM_RPORTS-1:0]                 rbusy;

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned j = 0; j < NUM_RPORTS; j++) begin
      if (bus.raddr_i[j] != '0) begin
        rdata[j] = mem_q[bus.raddr_i[j]];
      end
      rbusy[j] = busy_vec[bus.raddr_i[j]];
      if (BYPASS != 0) begin
        // A releasing write unblocks the consumer, which then takes the forwarded data.
        for (int unsigned k = 0; k < NUM_WPORTS; k++) begin
          if (bus.we_i[k] && (bus.waddr_i[k] == bus.raddr_i[j]) &&
              (bus.raddr_i[j] != '0)) begin
            rdata[j] = bus.wdata_i[k];
            if (bus.wrel_i[k]) begin
              rbusy[j] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.rdata_o    = rdata;
  assign bus.rbusy_o    = rbusy;
  assign bus.busy_vec_o = busy_vec;

endmodule

// File: tb/tb_riscv_register_file_sb.sv
// Directed bench: an integer-only file without bypass and an FP file with bypass, driven in step.
module tb_riscv_register_file_sb;
  import riscv_rf_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  riscv_register_file_sb_if #(.ADDR_WIDTH(5)) if0 ();
  riscv_register_file_sb_if #(.ADDR_WIDTH(6)) if1 ();

  riscv_register_file_sb #(.FPU(0), .BYPASS(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_en_i (1'b0),
    .bus       (if0)
  );

  riscv_register_file_sb #(.FPU(1), .BYPASS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_en_i (1'b0),
    .bus       (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we, wrel;
    rf_addr_t    wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rv, fl;
    rf_addr_t    rsv, ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  erb;
    logic        erdy;
    logic [31:0] ebusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] we, logic [1:0] wrel, rf_addr_t wa0, logic [31:0] wd0,
                              rf_addr_t wa1, logic [31:0] wd1, logic rv, rf_addr_t rsv,
                              logic fl, rf_addr_t ra0, rf_addr_t ra1, rf_addr_t ra2,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [2:0] erb, logic erdy, logic [31:0] ebusy);
    vec_t v;
    v.we = we; v.wrel = wrel; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rv = rv; v.rsv = rsv; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.erb = erb; v.erdy = erdy; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic drive(logic [1:0] we, logic [1:0] wrel, rf_addr_t wa0, logic [31:0] wd0,
                       rf_addr_t wa1, logic [31:0] wd1, logic rv, rf_addr_t rsv, logic fl,
                       rf_addr_t ra0, rf_addr_t ra1, rf_addr_t ra2);
    if0.we_i = we;          if1.we_i = we;
    if0.wrel_i = wrel;      if1.wrel_i = wrel;
    if0.waddr_i[0] = wa0[4:0]; if1.waddr_i[0] = wa0;
    if0.waddr_i[1] = wa1[4:0]; if1.waddr_i[1] = wa1;
    if0.wdata_i[0] = wd0;   if1.wdata_i[0] = wd0;
    if0.wdata_i[1] = wd1;   if1.wdata_i[1] = wd1;
    if0.rsv_valid_i = rv;   if1.rsv_valid_i = rv;
    if0.rsv_addr_i = rsv[4:0]; if1.rsv_addr_i = rsv;
    if0.flush_i = fl;       if1.flush_i = fl;
    if0.raddr_i[0] = ra0[4:0]; if1.raddr_i[0] = ra0;
    if0.raddr_i[1] = ra1[4:0]; if1.raddr_i[1] = ra1;
    if0.raddr_i[2] = ra2[4:0]; if1.raddr_i[2] = ra2;
  endtask

  task automatic idle(rf_addr_t ra0, rf_addr_t ra1, rf_addr_t ra2);
    drive(2'b00, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0, ra0, ra1, ra2);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    // v: we wrel wa0 wd0 wa1 wd1 rv rsv fl ra0 ra1 ra2 | e0 e1 e2 erb erdy ebusy
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31,
                      0, 0, 0, 3'b000, 0, 32'h0));
    vecs.push_back(mk(2'b01, 2'b00, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 7,
                      0, 0, 0, 3'b000, 0, 32'h0));
    vecs.push_back(mk(2'b11, 2'b00, 5, 32'h11111111, 5, 32'h22222222, 0, 0, 0, 0, 1, 2,
                      0, 0, 0, 3'b000, 0, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 7, 0, 5, 0, 3,
                      32'h22222222, 0, 0, 3'b000, 1, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 5, 0,
                      0, 32'h22222222, 0, 3'b001, 0, 32'h80));
    vecs.push_back(mk(2'b10, 2'b10, 0, 0, 7, 32'h5A, 0, 0, 0, 5, 1, 2,
                      32'h22222222, 0, 0, 3'b000, 0, 32'h80));
    vecs.push_back(mk(2'b01, 2'b01, 9, 32'h99, 0, 0, 1, 9, 0, 7, 0, 5,
                      32'h5A, 0, 32'h22222222, 3'b000, 1, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 7, 0,
                      32'h99, 32'h5A, 0, 3'b001, 0, 32'h200));
    vecs.push_back(mk(2'b01, 2'b01, 9, 32'h98, 0, 0, 1, 3, 0, 1, 2, 4,
                      0, 0, 0, 3'b000, 1, 32'h200));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 4, 0, 9, 3, 0,
                      32'h98, 0, 0, 3'b010, 1, 32'h8));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 6, 0, 4, 3, 6,
                      0, 0, 0, 3'b011, 1, 32'h18));
    vecs.push_back(mk(2'b01, 2'b00, 10, 32'hA0A0, 0, 0, 1, 8, 1, 6, 4, 3,
                      0, 0, 0, 3'b111, 0, 32'h58));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 10, 6, 8,
                      32'hA0A0, 0, 0, 3'b000, 1, 32'h0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 12, 0, 10, 0, 0,
                      32'hA0A0, 0, 0, 3'b000, 1, 32'h0));
    vecs.push_back(mk(2'b00, 2'b01, 12, 32'hFFFF, 0, 0, 1, 12, 0, 12, 0, 10,
                      0, 0, 32'hA0A0, 3'b001, 0, 32'h1000));
    vecs.push_back(mk(2'b11, 2'b01, 12, 32'h1, 12, 32'h2, 0, 0, 0, 9, 5, 0,
                      32'h98, 32'h22222222, 0, 3'b000, 0, 32'h1000));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0,
                      32'h2, 0, 0, 3'b000, 0, 32'h0));

    rst_n = 1'b0;
    idle(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wrel, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            vecs[i].rv, vecs[i].rsv, vecs[i].fl, vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
      #3;
      chk($sformatf("v%0d d0 rd0", i), 64'(if0.rdata_o[0]), 64'(vecs[i].e0));
      chk($sformatf("v%0d d0 rd1", i), 64'(if0.rdata_o[1]), 64'(vecs[i].e1));
      chk($sformatf("v%0d d0 rd2", i), 64'(if0.rdata_o[2]), 64'(vecs[i].e2));
      chk($sformatf("v%0d d0 rbusy", i), 64'(if0.rbusy_o), 64'(vecs[i].erb));
      chk($sformatf("v%0d d0 ready", i), 64'(if0.rsv_ready_o), 64'(vecs[i].erdy));
      chk($sformatf("v%0d d0 busy", i), 64'(if0.busy_vec_o), 64'(vecs[i].ebusy));
      chk($sformatf("v%0d d1 rd0", i), 64'(if1.rdata_o[0]), 64'(vecs[i].e0));
      chk($sformatf("v%0d d1 rd1", i), 64'(if1.rdata_o[1]), 64'(vecs[i].e1));
      chk($sformatf("v%0d d1 rd2", i), 64'(if1.rdata_o[2]), 64'(vecs[i].e2));
      chk($sformatf("v%0d d1 rbusy", i), 64'(if1.rbusy_o), 64'(vecs[i].erb));
      chk($sformatf("v%0d d1 ready", i), 64'(if1.rsv_ready_o), 64'(vecs[i].erdy));
      chk($sformatf("v%0d d1 busy", i), if1.busy_vec_o, 64'(vecs[i].ebusy));
    end

    // Same-cycle double write to x5: bypass sees the port-1 data, the plain file the old value.
    @(negedge clk);
    drive(2'b11, 2'b00, 5, 32'h33, 5, 32'h44, 1'b0, 0, 1'b0, 5, 0, 0);
    #3;
    chk("byp d1 rd x5", 64'(if1.rdata_o[0]), 64'h44);
    chk("byp d0 rd x5", 64'(if0.rdata_o[0]), 64'h22222222);
    @(negedge clk);
    idle(5, 0, 0);
    #3;
    chk("wr d1 x5", 64'(if1.rdata_o[0]), 64'h44);
    chk("wr d0 x5", 64'(if0.rdata_o[0]), 64'h44);

    // Releasing write to a busy register: bypass masks rbusy and forwards the data.
    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 20, 1'b0, 0, 0, 0);
    @(negedge clk);
    drive(2'b01, 2'b01, 20, 32'h2020, 0, 0, 1'b0, 0, 1'b0, 20, 0, 0);
    #3;
    chk("rel d1 rd", 64'(if1.rdata_o[0]), 64'h2020);
    chk("rel d1 rbusy", 64'(if1.rbusy_o[0]), 64'h0);
    chk("rel d0 rd", 64'(if0.rdata_o[0]), 64'h0);
    chk("rel d0 rbusy", 64'(if0.rbusy_o[0]), 64'h1);
    @(negedge clk);
    idle(20, 0, 0);
    #3;
    chk("rel d0 rd after", 64'(if0.rdata_o[0]), 64'h2020);
    chk("rel d0 busy after", 64'(if0.busy_vec_o), 64'h0);
    chk("rel d1 busy after", if1.busy_vec_o, 64'h0);

    // FP register f0 (address 32) is real storage; x0 still discards writes.
    @(negedge clk);
    drive(2'b11, 2'b00, 32, 32'h3F800000, 0, 32'h1, 1'b1, 33, 1'b0, 0, 0, 0);
    #3;
    chk("fp d1 ready", 64'(if1.rsv_ready_o), 64'h1);
    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 33, 1'b0, 32, 0, 33);
    #3;
    chk("fp d1 rd f0", 64'(if1.rdata_o[0]), 64'h3F800000);
    chk("fp d1 rd x0", 64'(if1.rdata_o[1]), 64'h0);
    chk("fp d1 rbusy", 64'(if1.rbusy_o), 64'h4);
    chk("fp d1 busy", if1.busy_vec_o, 64'h1 << 33);
    chk("fp d1 waw", 64'(if1.rsv_ready_o), 64'h0);

    // Reset dropped between edges clears everything without waiting for a clock.
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst d1 rd f0", 64'(if1.rdata_o[0]), 64'h0);
    chk("rst d1 rbusy", 64'(if1.rbusy_o), 64'h0);
    chk("rst d1 busy", if1.busy_vec_o, 64'h0);
    chk("rst d0 busy", 64'(if0.busy_vec_o), 64'h0);
    chk("rst d1 ready", 64'(if1.rsv_ready_o), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5, 7, 32);
    #3;
    chk("post rst d1 x5", 64'(if1.rdata_o[0]), 64'h0);
    chk("post rst d1 x7", 64'(if1.rdata_o[1]), 64'h0);
    chk("post rst d0 x5", 64'(if0.rdata_o[0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
